// File: rtl/pipe_pkg.sv
// Purpose : Shared definitions for the pipeline stage registers (pipe_reg_skid).
//           Holds the handshake state encoding and the default payload width
//           that every stage instance uses.
// Contents: state_e  - EMPTY / FULL / SKID occupancy of one stage.
//           PIPE_WIDTH - default payload width for a stage register.
package pipe_pkg;

  // Default payload width shared by all stage instances.
  localparam int PIPE_WIDTH = 32;

  // Occupancy of a stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

endpackage : pipe_pkg

// File: rtl/en_reg.sv
// Purpose : WIDTH-bit data register with load enable and asynchronous
//           active-low reset to RESET_VALUE. Used for the main and skid
//           payload slots of pipe_reg_skid.
// Ports   : clk   - clock, loads on the rising edge
//           rst   - asynchronous active-low reset
//           en_i  - load d_i this cycle
//           d_i   - next payload
//           q_o   - held payload
module en_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Payload storage: reset to RESET_VALUE, otherwise load when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= RESET_VALUE;
    end else if (en_i) begin
      data_q <= d_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o = data_q;

endmodule : en_reg

// File: rtl/pipe_reg_skid.sv
// Purpose : Pipeline stage register with valid/ready handshake and a
//           one-entry skid buffer. in_ready is decoded from registered state
//           only, so no combinational ready path crosses the stage. flush
//           squashes all held beats synchronously.
// Ports   : clk, rst (async active-low), flush
//           in_valid / in_ready / in_data    - upstream side
//           out_valid / out_ready / out_data - downstream side
//           stall_cnt - saturating count of cycles with out_valid && !out_ready
// Config  : define PIPE_REG_STATS_EN to build the stall_cnt port and counter;
//           otherwise the port is absent and CNT_W is unused.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  state_e           state_q;
  state_e           state_d;
  logic             accept_s;
  logic             emit_s;
  logic             main_en_s;
  logic             skid_en_s;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign accept_s = in_valid && in_ready;
  assign emit_s   = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) state_d = FULL;
          else          state_d = EMPTY;
        end
        FULL: begin
          if (emit_s && !accept_s)      state_d = EMPTY;
          else if (accept_s && !emit_s) state_d = SKID;
          else                          state_d = FULL;
        end
        SKID: begin
          if (emit_s) state_d = FULL;
          else        state_d = SKID;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs and data-path load controls, decoded from state.
  // Data registers are left untouched in a flush cycle.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    main_en_s = 1'b0;
    skid_en_s = 1'b0;
    main_d    = in_data;
    case (state_q)
      EMPTY: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        main_en_s = !flush && in_valid;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
        main_en_s = !flush && in_valid && out_ready;
        skid_en_s = !flush && in_valid && !out_ready;
      end
      SKID: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        main_en_s = !flush && out_ready;
        main_d    = skid_q;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
    endcase
  end

  en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .en_i (main_en_s),
    .d_i  (main_d),
    .q_o  (out_data)
  );

  en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .en_i (skid_en_s),
    .d_i  (in_data),
    .q_o  (skid_q)
  );

`ifdef PIPE_REG_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating stall counter; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : pipe_reg_skid

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: reset, streaming, back-pressure with skid,
// flush in SKID, asynchronous reset while FULL and, with PIPE_REG_STATS_EN,
// stall counter saturation at CNT_W = 4.
module tb_pipe_reg_skid;

  localparam int          W     = 32;
  localparam logic [31:0] RSTV  = 32'h0000_00C3;
  localparam int          CW    = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_REG_STATS_EN
  logic [CW-1:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_reg_skid #(
    .WIDTH       (W),
    .RESET_VALUE (RSTV),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #12;
    chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rst_iready", {31'd0, in_ready}, 32'd1);
    chk("rst_odata", out_data, RSTV);
`ifdef PIPE_REG_STATS_EN
    chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
`endif
    rst = 1'b1;
    step();
    chk("idle_ovalid", {31'd0, out_valid}, 32'd0);
    chk("idle_iready", {31'd0, in_ready}, 32'd1);

    // Stream at full rate.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'(i);
      step();
      chk("strm_data", out_data, 32'(i));
      chk("strm_ovalid", {31'd0, out_valid}, 32'd1);
      chk("strm_iready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_drain", {31'd0, out_valid}, 32'd0);

    // Back-pressure: A in main, B in skid, C refused until release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    chk("bp_a", out_data, 32'hA);
    in_data = 32'hB;
    step();
    chk("bp_skid_iready", {31'd0, in_ready}, 32'd0);
    chk("bp_skid_data", out_data, 32'hA);
    in_data = 32'hC;
    step();
    chk("bp_hold_data", out_data, 32'hA);
    chk("bp_hold_iready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_b", out_data, 32'hB);
    chk("bp_b_iready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_c", out_data, 32'hC);
    chk("bp_c_ovalid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while in SKID with a beat offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    chk("fl_pre_iready", {31'd0, in_ready}, 32'd0);
    flush   = 1'b1;
    in_data = 32'h55;
    step();
    chk("fl_ovalid", {31'd0, out_valid}, 32'd0);
    chk("fl_iready", {31'd0, in_ready}, 32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_no55", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h66;
    step();
    chk("fl_restart", out_data, 32'h66);
    chk("fl_restart_v", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset while FULL.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    chk("ar_full", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_ovalid", {31'd0, out_valid}, 32'd0);
    chk("ar_odata", out_data, RSTV);
    chk("ar_iready", {31'd0, in_ready}, 32'd1);
    #1;
    rst = 1'b1;
    step();
    chk("ar_after", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_REG_STATS_EN
    // Stall counter saturates at 15.
    in_valid = 1'b1;
    in_data  = 32'h77;
    step();
    in_valid = 1'b0;
    chk("st_0", {28'd0, stall_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("st_5", {28'd0, stall_cnt}, 32'd5);
    for (int i = 0; i < 15; i++) step();
    chk("st_sat", {28'd0, stall_cnt}, 32'd15);
    step();
    chk("st_hold", {28'd0, stall_cnt}, 32'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_flush", {28'd0, stall_cnt}, 32'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_reg_skid

// File: doc/pipe_reg_skid.md
# pipe_reg_skid

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing plain enable-gated stage registers. It gives full one-per-cycle throughput under back-pressure and a synchronous flush for branch and exception squash. `in_ready` is driven only from registered state, which breaks the combinational ready path between stages.

## Interface

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VALUE, '0, value loaded into the main and skid data registers on reset.
- CNT_W, 16, width of the stall counter (used only with PIPE_REG_STATS_EN).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload driven from the main register.
- stall_cnt  output  CNT_W  stall statistics (PIPE_REG_STATS_EN only).

## Operation

- Storage:
  - main register, which always drives out_data.
  - skid register.
  - 2-bit state: EMPTY, FULL, SKID.
- Outputs decoded from state only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != SKID).
- Accept = in_valid && in_ready. Emit = out_valid && out_ready.
- EMPTY:
  - accept → main <= in_data, go to FULL.
- FULL:
  - accept && emit → main <= in_data, stay FULL.
  - emit only → EMPTY.
  - accept only → skid <= in_data, go to SKID.
  - neither → hold.
- SKID:
  - emit → main <= skid, go to FULL.
  - otherwise hold.
  - No accept is possible, since in_ready = 0.
- flush has priority over all transitions:
  - Next state is EMPTY.
  - Data registers keep their contents; out_data is don't-care while out_valid = 0.
  - If in_valid is high in the flush cycle, the beat completes the handshake (in_ready may be 1) but is discarded.
  - An emit in the flush cycle is still a valid transfer downstream.
- Ordering: strict FIFO. Skid contents are never emitted before main.
- No payload arithmetic; data passes through bit-exact.

## Timing

- Reset (rst = 0, asynchronous):
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out_data = RESET_VALUE, skid = RESET_VALUE, stall_cnt = 0.
- Latency: a beat accepted at edge N is visible on out_data and out_valid after edge N.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready falls the cycle after the skid fills, so one beat of upstream overrun is always absorbed.
- Reset asserted mid-transfer: all held beats are lost immediately and outputs go to their reset values without waiting for a clock edge.
- Back-pressure release: SKID → FULL on the first out_ready cycle. in_ready returns to 1 on the following cycle.

## Configuration

- Macro: PIPE_REG_STATS_EN.
- Defined:
  - stall_cnt increments on every cycle with out_valid && !out_ready.
  - It saturates at 2^CNT_W − 1.
  - It is cleared by reset only; flush does not clear it.
- Undefined:
  - stall_cnt port and counter are absent.
  - CNT_W is unused.
  - Handshake behaviour is identical in both builds.

## Structure

- Shared package pipe_pkg holds:
  - the state enum typedef (EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2);
  - the default WIDTH constant, shared by all stage instances.
- Sub-module en_reg: WIDTH-parametrised, async active-low reset to RESET_VALUE, load on enable.
  - Instantiated twice, for main and skid.
  - The control FSM and optional counter stay in pipe_reg_skid.

## Test plan

- Reset released with in_valid = 0 → out_valid = 0, in_ready = 1, out_data = RESET_VALUE, stall_cnt = 0.
- Stream 0x1, 0x2, 0x3 with out_ready = 1 every cycle:
  - each value appears one cycle after acceptance;
  - in_ready never drops.
- Stream 0xA, 0xB, 0xC with out_ready = 0 from cycle 1:
  - 0xA is held in main, 0xB in skid, in_ready = 0;
  - raise out_ready → output order 0xA, 0xB, then 0xC; no loss or duplication.
- Assert flush in SKID state with in_valid = 1, in_data = 0x55 → next cycle out_valid = 0, in_ready = 1; 0x55 is never emitted.
- Pulse rst low while FULL → out_valid = 0 and out_data = RESET_VALUE immediately, before the next clk edge.
- With PIPE_REG_STATS_EN and CNT_W = 4, hold out_valid = 1 and out_ready = 0 for 20 cycles → stall_cnt = 15 and stays there.
